// File: rtl/imem_boot_loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : imem_boot_loader_pkg                                            |
// | Brief    : Shared state encoding and sizing helpers for the boot loader.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package imem_boot_loader_pkg;

    localparam int unsigned c_HDR_BYTES = 2;
    localparam int unsigned c_ST_W      = 3;

    typedef logic [c_ST_W-1:0] state_t;

    localparam state_t c_ST_LEN_HI = 3'd0;
    localparam state_t c_ST_LEN_LO = 3'd1;
    localparam state_t c_ST_DATA   = 3'd2;
    localparam state_t c_ST_DONE   = 3'd3;
    localparam state_t c_ST_RUN    = 3'd4;

    // Word capacity of a byte-addressed memory holding 32-bit words.
    function automatic int unsigned cap_words(input int unsigned addr_width);
        return 32'd1 << (addr_width - 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_boot_loader_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : imem_boot_loader_if                                             |
// | Brief    : Byte-stream input and instruction-memory write port bundle.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface imem_boot_loader_if;

    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [31:0] imem_waddr;
    logic [31:0] imem_wdata;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  imem_we,
        input  imem_waddr,
        input  imem_wdata
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output imem_we,
        output imem_waddr,
        output imem_wdata
    );

endinterface
`default_nettype wire

// File: rtl/imem_word_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : imem_word_packer                                                |
// | Brief    : Packs bytes MSB-first into 32-bit words; flags the 4th byte.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module imem_word_packer
    import imem_boot_loader_pkg::*;
(
    input  wire         clk,
    input  wire         rst,
    input  wire         i_clr,
    input  wire         i_byte_valid,
    input  wire  [7:0]  i_byte,
    output logic        o_word_done,
    output logic [31:0] o_word
);

    logic [1:0]  r_byte_cnt;
    logic [23:0] r_shift;

    always_ff @(posedge clk) begin
        if (!rst || i_clr) begin
            r_byte_cnt <= 2'd0;
            r_shift    <= 24'd0;
        end else if (i_byte_valid) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            r_shift    <= {r_shift[15:0], i_byte};
        end
    end

    // The word is presented together with its final byte so the caller can
    // register it on the same edge that accepts that byte.
    assign o_word_done = i_byte_valid && (r_byte_cnt == 2'd3);
    assign o_word      = {r_shift, i_byte};

endmodule
`default_nettype wire

// File: rtl/imem_boot_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : imem_boot_loader                                                |
// | Brief    : Loads a length-prefixed byte stream into instruction memory     |
// |            and holds the CPU in reset until the last word is committed.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = 16
) (
    input  wire                  clk,
    input  wire                  rst,
    imem_boot_loader_if.slave    bus,
    input  wire                  load_req,
    output logic                 cpu_rst_n,
    output logic [LEN_WIDTH-1:0] loaded_words,
    output logic                 err_overflow
);

    localparam int unsigned            c_CAP   = cap_words(ADDR_WIDTH);
    localparam logic [LEN_WIDTH:0]     c_CAP_L = c_CAP[LEN_WIDTH:0];
    localparam logic [LEN_WIDTH-1:0]   c_ONE   = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

    state_t                r_state;
    state_t                w_state_nxt;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  w_len_nxt;
    logic [LEN_WIDTH-1:0]  r_word_idx;
    logic [LEN_WIDTH-1:0]  w_word_idx_nxt;
    logic [LEN_WIDTH-1:0]  r_loaded;
    logic [LEN_WIDTH-1:0]  w_loaded_nxt;
    logic                  r_we;
    logic                  w_we_nxt;
    logic [31:0]           r_waddr;
    logic [31:0]           w_waddr_nxt;
    logic [31:0]           r_wdata;
    logic [31:0]           w_wdata_nxt;
    logic                  r_cpu_rst_n;
    logic                  w_cpu_rst_n_nxt;
    logic                  r_err;
    logic                  w_err_nxt;

    logic                  w_ready;
    logic                  w_hs;
    logic                  w_pack_valid;
    logic                  w_pack_clr;
    logic                  w_word_done;
    logic [31:0]           w_word;
    logic [LEN_WIDTH-1:0]  w_len_shift;
    logic [LEN_WIDTH-1:0]  w_idx_inc;

    assign w_ready = rst && ((r_state == c_ST_LEN_HI) ||
                             (r_state == c_ST_LEN_LO) ||
                             (r_state == c_ST_DATA));
    assign w_hs         = bus.in_valid && w_ready;
    assign w_pack_valid = w_hs && (r_state == c_ST_DATA);
    assign w_len_shift  = {r_len[LEN_WIDTH-9:0], bus.in_data};
    assign w_idx_inc    = r_word_idx + c_ONE;

    imem_word_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .i_clr        (w_pack_clr),
        .i_byte_valid (w_pack_valid),
        .i_byte       (bus.in_data),
        .o_word_done  (w_word_done),
        .o_word       (w_word)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_len_nxt       = r_len;
        w_word_idx_nxt  = r_word_idx;
        w_loaded_nxt    = r_loaded;
        w_we_nxt        = 1'b0;
        w_waddr_nxt     = r_waddr;
        w_wdata_nxt     = r_wdata;
        w_cpu_rst_n_nxt = r_cpu_rst_n;
        w_err_nxt       = r_err;
        w_pack_clr      = 1'b0;

        case (r_state)
            c_ST_LEN_HI: begin
                if (w_hs) begin
                    w_len_nxt   = {{(LEN_WIDTH-8){1'b0}}, bus.in_data};
                    w_state_nxt = c_ST_LEN_LO;
                end
            end
            c_ST_LEN_LO: begin
                if (w_hs) begin
                    w_len_nxt   = w_len_shift;
                    w_err_nxt   = ({1'b0, w_len_shift} > c_CAP_L);
                    w_state_nxt = (w_len_shift == '0) ? c_ST_DONE : c_ST_DATA;
                end
            end
            c_ST_DATA: begin
                if (w_word_done) begin
                    // Words beyond capacity are drained from the stream unwritten.
                    if ({1'b0, r_word_idx} < c_CAP_L) begin
                        w_we_nxt     = 1'b1;
                        w_waddr_nxt  = {{(32-ADDR_WIDTH){1'b0}},
                                        r_word_idx[ADDR_WIDTH-3:0], 2'b00};
                        w_wdata_nxt  = w_word;
                        w_loaded_nxt = r_loaded + c_ONE;
                    end
                    w_word_idx_nxt = w_idx_inc;
                    if (w_idx_inc == r_len) begin
                        w_state_nxt = c_ST_DONE;
                    end
                end
            end
            c_ST_DONE: begin
                w_state_nxt     = c_ST_RUN;
                w_cpu_rst_n_nxt = 1'b1;
            end
            c_ST_RUN: begin
                if (load_req) begin
                    w_state_nxt     = c_ST_LEN_HI;
                    w_cpu_rst_n_nxt = 1'b0;
                    w_word_idx_nxt  = '0;
                    w_loaded_nxt    = '0;
                    w_err_nxt       = 1'b0;
                    w_pack_clr      = 1'b1;
                end
            end
            default: begin
                w_state_nxt     = c_ST_LEN_HI;
                w_cpu_rst_n_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= c_ST_LEN_HI;
            r_len       <= '0;
            r_word_idx  <= '0;
            r_loaded    <= '0;
            r_we        <= 1'b0;
            r_waddr     <= 32'd0;
            r_wdata     <= 32'd0;
            r_cpu_rst_n <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_len       <= w_len_nxt;
            r_word_idx  <= w_word_idx_nxt;
            r_loaded    <= w_loaded_nxt;
            r_we        <= w_we_nxt;
            r_waddr     <= w_waddr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_cpu_rst_n <= w_cpu_rst_n_nxt;
            r_err       <= w_err_nxt;
        end
    end

    assign bus.in_ready   = w_ready;
    assign bus.imem_we    = r_we;
    assign bus.imem_waddr = r_waddr;
    assign bus.imem_wdata = r_wdata;
    assign cpu_rst_n      = r_cpu_rst_n;
    assign loaded_words   = r_loaded;
    assign err_overflow   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_imem_boot_loader                                             |
// | Brief    : Self-checking bench for the instruction-memory boot loader.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_imem_boot_loader;

    localparam int ADDR_WIDTH = 10;
    localparam int LEN_WIDTH  = 16;
    localparam int CAP        = 1 << (ADDR_WIDTH - 2);

    logic                 clk      = 1'b0;
    logic                 rst      = 1'b0;
    logic                 load_req = 1'b0;
    logic                 cpu_rst_n;
    logic [LEN_WIDTH-1:0] loaded_words;
    logic                 err_overflow;

    imem_boot_loader_if bus();

    imem_boot_loader #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .load_req     (load_req),
        .cpu_rst_n    (cpu_rst_n),
        .loaded_words (loaded_words),
        .err_overflow (err_overflow)
    );

    always #5 clk = ~clk;

    int vectors      = 0;
    int errors       = 0;
    int drv_timeouts = 0;

    logic [7:0]  stim_q[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    int          exp_loaded;
    bit          exp_err;

    // Write/release observer, sampled on the falling edge.
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int   cyc         = 0;
    int   last_we_cyc = -1;
    int   rise_cyc    = -1;
    int   dbl_we      = 0;
    logic prev_we     = 1'b0;
    logic prev_cpu    = 1'b0;

    always @(negedge clk) begin
        cyc      <= cyc + 1;
        prev_we  <= bus.imem_we;
        prev_cpu <= cpu_rst_n;
        if (bus.imem_we === 1'b1) begin
            wr_addr_q.push_back(bus.imem_waddr);
            wr_data_q.push_back(bus.imem_wdata);
            last_we_cyc <= cyc;
            if (prev_we === 1'b1) dbl_we <= dbl_we + 1;
        end
        if (cpu_rst_n === 1'b1 && prev_cpu === 1'b0) rise_cyc <= cyc;
    end

    // Reference: header gives word count, words are big-endian, first CAP are stored.
    function automatic void run_model();
        int len;
        len = (int'(stim_q[0]) << 8) | int'(stim_q[1]);
        exp_addr.delete();
        exp_data.delete();
        for (int w = 0; w < len; w++) begin
            logic [31:0] word;
            word = 32'd0;
            for (int b = 0; b < 4; b++) word = (word << 8) | 32'(stim_q[2 + 4*w + b]);
            if (w < CAP) begin
                exp_addr.push_back(32'(w * 4));
                exp_data.push_back(word);
            end
        end
        exp_loaded = (len < CAP) ? len : CAP;
        exp_err    = (len > CAP);
    endfunction

    task automatic make_stream(input int len, input int nwords);
        stim_q.delete();
        stim_q.push_back(8'(len >> 8));
        stim_q.push_back(8'(len));
        repeat (nwords * 4) stim_q.push_back(8'($urandom));
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int gap;
        int n;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        n   = 0;
        repeat (gap) begin
            bus.in_valid = 1'b0;
            @(negedge clk);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (bus.in_ready !== 1'b1) drv_timeouts++;
        @(negedge clk);
    endtask

    task automatic send_range(input int first, input int last, input int max_gap);
        for (int i = first; i <= last; i++) send_byte(stim_q[i], max_gap);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_release(output bit timed_out);
        int n;
        n = 0;
        while (cpu_rst_n !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        timed_out = (cpu_rst_n !== 1'b1);
        @(negedge clk);
        #1;
    endtask

    task automatic reload();
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic test_reset();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(negedge clk);
        vectors++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
        vectors++; if (bus.imem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", bus.imem_we); end
        vectors++; if (bus.imem_waddr !== 32'd0 || bus.imem_wdata !== 32'd0) begin errors++; $display("FAIL reset_wport: got %h/%h want 0/0", bus.imem_waddr, bus.imem_wdata); end
        vectors++; if (cpu_rst_n !== 1'b0 || loaded_words !== '0 || err_overflow !== 1'b0) begin errors++; $display("FAIL reset_status: got cpu=%b loaded=%0d err=%b want 0/0/0", cpu_rst_n, loaded_words, err_overflow); end
        rst = 1'b1;
        @(negedge clk);
        vectors++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_basic();
        int n0; int d0; bit to;
        n0 = wr_addr_q.size(); d0 = dbl_we;
        stim_q = '{8'h00, 8'h02, 8'h3c, 8'h01, 8'h10, 8'h01, 8'h34, 8'h3d, 8'h00, 8'h28};
        run_model();
        send_range(0, stim_q.size() - 1, 0);
        wait_release(to);
        vectors++; if (to || drv_timeouts != 0) begin errors++; $display("FAIL basic_release: got cpu=%b stalls=%0d want 1/0", cpu_rst_n, drv_timeouts); end
        vectors++; if (wr_addr_q.size() - n0 != exp_addr.size()) begin errors++; $display("FAIL basic_count: got %0d want %0d", wr_addr_q.size() - n0, exp_addr.size()); end
        for (int i = 0; i < exp_addr.size() && n0 + i < wr_addr_q.size(); i++) begin
            vectors++; if (wr_addr_q[n0+i] !== exp_addr[i] || wr_data_q[n0+i] !== exp_data[i]) begin errors++; $display("FAIL basic_write[%0d]: got %h/%h want %h/%h", i, wr_addr_q[n0+i], wr_data_q[n0+i], exp_addr[i], exp_data[i]); end
        end
        vectors++; if (rise_cyc != last_we_cyc + 1) begin errors++; $display("FAIL basic_release_timing: got rise@%0d want %0d", rise_cyc, last_we_cyc + 1); end
        vectors++; if (loaded_words !== LEN_WIDTH'(exp_loaded) || err_overflow !== exp_err) begin errors++; $display("FAIL basic_status: got %0d/%b want %0d/%b", loaded_words, err_overflow, exp_loaded, exp_err); end
        vectors++; if (bus.in_ready !== 1'b0 || dbl_we != d0) begin errors++; $display("FAIL basic_idle: got ready=%b dbl=%0d want 0/%0d", bus.in_ready, dbl_we, d0); end
    endtask

    task automatic test_gaps(input int iter, input bit fixed_stream);
        int n0; int d0; bit to;
        reload();
        n0 = wr_addr_q.size(); d0 = dbl_we;
        if (fixed_stream) stim_q = '{8'h00, 8'h02, 8'h3c, 8'h01, 8'h10, 8'h01, 8'h34, 8'h3d, 8'h00, 8'h28};
        else begin int nw; nw = int'($urandom_range(6, 1)); make_stream(nw, nw); end
        run_model();
        send_range(0, stim_q.size() - 1, 5);
        wait_release(to);
        vectors++; if (to) begin errors++; $display("FAIL gaps%0d_release: got cpu=%b want 1", iter, cpu_rst_n); end
        vectors++; if (wr_addr_q.size() - n0 != exp_addr.size()) begin errors++; $display("FAIL gaps%0d_count: got %0d want %0d", iter, wr_addr_q.size() - n0, exp_addr.size()); end
        for (int i = 0; i < exp_addr.size() && n0 + i < wr_addr_q.size(); i++) begin
            vectors++; if (wr_addr_q[n0+i] !== exp_addr[i] || wr_data_q[n0+i] !== exp_data[i]) begin errors++; $display("FAIL gaps%0d_write[%0d]: got %h/%h want %h/%h", iter, i, wr_addr_q[n0+i], wr_data_q[n0+i], exp_addr[i], exp_data[i]); end
        end
        vectors++; if (loaded_words !== LEN_WIDTH'(exp_loaded) || dbl_we != d0) begin errors++; $display("FAIL gaps%0d_status: got loaded=%0d dbl=%0d want %0d/%0d", iter, loaded_words, dbl_we, exp_loaded, d0); end
    endtask

    task automatic test_empty();
        int n0; bit to;
        reload();
        n0 = wr_addr_q.size();
        make_stream(0, 0);
        send_range(0, 1, 0);
        vectors++; if (cpu_rst_n !== 1'b0) begin errors++; $display("FAIL empty_done_cycle: got cpu=%b want 0", cpu_rst_n); end
        wait_release(to);
        vectors++; if (to) begin errors++; $display("FAIL empty_release: got cpu=%b want 1", cpu_rst_n); end
        vectors++; if (wr_addr_q.size() != n0 || loaded_words !== '0) begin errors++; $display("FAIL empty_writes: got %0d writes loaded=%0d want 0/0", wr_addr_q.size() - n0, loaded_words); end
    endtask

    task automatic test_overflow();
        int n0; int bad; bit to;
        reload();
        n0 = wr_addr_q.size(); bad = 0;
        make_stream(CAP + 1, CAP + 1);
        run_model();
        send_range(0, stim_q.size() - 1, 0);
        wait_release(to);
        vectors++; if (to) begin errors++; $display("FAIL ovf_release: got cpu=%b want 1", cpu_rst_n); end
        vectors++; if (wr_addr_q.size() - n0 != exp_addr.size()) begin errors++; $display("FAIL ovf_count: got %0d want %0d", wr_addr_q.size() - n0, exp_addr.size()); end
        for (int i = 0; i < exp_addr.size() && n0 + i < wr_addr_q.size(); i++) begin
            vectors++; if (wr_addr_q[n0+i] !== exp_addr[i] || wr_data_q[n0+i] !== exp_data[i]) begin errors++; if (bad++ < 4) $display("FAIL ovf_write[%0d]: got %h/%h want %h/%h", i, wr_addr_q[n0+i], wr_data_q[n0+i], exp_addr[i], exp_data[i]); end
        end
        vectors++; if (err_overflow !== 1'b1 || loaded_words !== LEN_WIDTH'(exp_loaded)) begin errors++; $display("FAIL ovf_status: got err=%b loaded=%0d want 1/%0d", err_overflow, loaded_words, exp_loaded); end
    endtask

    task automatic test_reload();
        int n0; bit to;
        vectors++; if (cpu_rst_n !== 1'b1 || err_overflow !== 1'b1) begin errors++; $display("FAIL reload_pre: got cpu=%b err=%b want 1/1", cpu_rst_n, err_overflow); end
        load_req = 1'b1;
        @(posedge clk);
        #1;
        vectors++; if (cpu_rst_n !== 1'b0 || err_overflow !== 1'b0 || loaded_words !== '0) begin errors++; $display("FAIL reload_edge: got cpu=%b err=%b loaded=%0d want 0/0/0", cpu_rst_n, err_overflow, loaded_words); end
        @(negedge clk);
        load_req = 1'b0;
        n0 = wr_addr_q.size();
        stim_q = '{8'h00, 8'h01, 8'h24, 8'h09, 8'h00, 8'h02};
        run_model();
        send_range(0, 3, 2);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        send_range(4, 5, 2);
        wait_release(to);
        vectors++; if (to) begin errors++; $display("FAIL reload_release: got cpu=%b want 1", cpu_rst_n); end
        vectors++; if (wr_addr_q.size() - n0 != 1) begin errors++; $display("FAIL reload_count: got %0d want 1", wr_addr_q.size() - n0); end
        else begin
            vectors++; if (wr_addr_q[n0] !== exp_addr[0] || wr_data_q[n0] !== exp_data[0]) begin errors++; $display("FAIL reload_write: got %h/%h want %h/%h", wr_addr_q[n0], wr_data_q[n0], exp_addr[0], exp_data[0]); end
        end
        vectors++; if (loaded_words !== 16'd1 || err_overflow !== 1'b0) begin errors++; $display("FAIL reload_status: got %0d/%b want 1/0", loaded_words, err_overflow); end
    endtask

    task automatic test_reset_midload();
        int n0; bit to;
        reload();
        n0 = wr_addr_q.size();
        make_stream(1, 1);
        send_range(0, 3, 0);
        rst          = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hff;
        @(negedge clk);
        vectors++; if (bus.in_ready !== 1'b0 || bus.imem_we !== 1'b0) begin errors++; $display("FAIL midrst_ready_we: got %b/%b want 0/0", bus.in_ready, bus.imem_we); end
        vectors++; if (bus.imem_waddr !== 32'd0 || bus.imem_wdata !== 32'd0) begin errors++; $display("FAIL midrst_wport: got %h/%h want 0/0", bus.imem_waddr, bus.imem_wdata); end
        vectors++; if (cpu_rst_n !== 1'b0 || loaded_words !== '0 || err_overflow !== 1'b0) begin errors++; $display("FAIL midrst_status: got %b/%0d/%b want 0/0/0", cpu_rst_n, loaded_words, err_overflow); end
        bus.in_valid = 1'b0;
        rst          = 1'b1;
        @(negedge clk);
        make_stream(1, 1);
        run_model();
        send_range(0, stim_q.size() - 1, 2);
        wait_release(to);
        vectors++; if (to) begin errors++; $display("FAIL midrst_release: got cpu=%b want 1", cpu_rst_n); end
        vectors++; if (wr_addr_q.size() - n0 != 1) begin errors++; $display("FAIL midrst_count: got %0d want 1", wr_addr_q.size() - n0); end
        else begin
            vectors++; if (wr_addr_q[n0] !== exp_addr[0] || wr_data_q[n0] !== exp_data[0]) begin errors++; $display("FAIL midrst_write: got %h/%h want %h/%h", wr_addr_q[n0], wr_data_q[n0], exp_addr[0], exp_data[0]); end
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        test_reset();
        test_basic();
        test_gaps(0, 1'b1);
        for (int k = 1; k <= 3; k++) test_gaps(k, 1'b0);
        test_empty();
        test_overflow();
        test_reload();
        test_reset_midload();
        vectors++; if (drv_timeouts != 0) begin errors++; $display("FAIL driver_stalls: got %0d want 0", drv_timeouts); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
